// File: rtl/inst_fetch_bridge.sv
// inst_fetch_bridge: fetches 32-bit instructions as two half-word reads from a 16-bit async memory,
// holding the last instruction in a one-entry buffer and stalling the core while a fetch is outstanding.
module inst_fetch_bridge #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce_i,
  input  logic [31:0]       rom_addr_i,
  output logic [31:0]       rom_data_o,
  output logic              stallreq_o,
  input  logic              flush_i,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  input  logic [15:0]       sram_data_i
);
  typedef enum logic [1:0] {IDLE, RD_LO, RD_HI} state_e;
  state_e            state_q;
  logic [3:0]        wait_q;
  logic [31:2]       addr_q;
  logic [31:2]       tag_q;
  logic              valid_q;
  logic [31:0]       data_q;
  logic [15:0]       lo_q;
  logic [ADDR_W-1:0] sram_addr_q;
  logic              hit;
  logic              busy;
  logic              last_wait;
  logic              unused;
  assign unused      = ^rom_addr_i[1:0];
  assign hit         = rom_ce_i & valid_q & (tag_q == rom_addr_i[31:2]);
  assign busy        = state_q != IDLE;
  assign last_wait   = wait_q == 4'(WAIT_CYCLES - 1);
  assign rom_data_o  = hit ? data_q : 32'h0;
  assign stallreq_o  = rom_ce_i & ~hit;
  assign sram_ce_n_o = ~busy;
  assign sram_oe_n_o = ~busy;
  // Address bus keeps its last driven value while idle
  assign sram_addr_o = busy ? {addr_q[ADDR_W:2], state_q == RD_HI} : sram_addr_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      addr_q      <= '0;
      tag_q       <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      lo_q        <= '0;
      sram_addr_q <= '0;
    end else begin
      sram_addr_q <= sram_addr_o;
      if (flush_i) begin
        valid_q <= 1'b0;
        state_q <= IDLE;
        wait_q  <= '0;
      end else if (!rom_ce_i) begin
        state_q <= IDLE;
        wait_q  <= '0;
      end else if (busy ? (rom_addr_i[31:2] != addr_q) : !hit) begin
        addr_q  <= rom_addr_i[31:2];
        state_q <= RD_LO;
        wait_q  <= '0;
      end else if (busy) begin
        if (!last_wait) begin
          wait_q <= wait_q + 4'd1;
        end else begin
          wait_q <= '0;
          if (state_q == RD_LO) begin
            lo_q    <= sram_data_i;
            state_q <= RD_HI;
          end else begin
            data_q  <= {sram_data_i, lo_q};
            tag_q   <= addr_q;
            valid_q <= 1'b1;
            state_q <= IDLE;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_inst_fetch_bridge.sv
// tb_inst_fetch_bridge: drives two bridges (W=2 and W=1) from one random stimulus stream
// and checks them against a cycle-count reference model through per-DUT scoreboards.
module tb_inst_fetch_bridge;
  typedef struct packed {
    logic [31:0] data;
    logic        stall;
    logic        ce_n;
    logic [19:0] addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b0;
  logic [31:0] addr = '0;
  logic        flush = 1'b0;
  logic [31:0] rd0, rd1;
  logic        st0, st1, cen0, cen1, oen0, oen1;
  logic [19:0] sa0, sa1;
  logic [15:0] sd0, sd1;
  logic [15:0] mem [256];

  int n_cmp = 0;
  int n_bad = 0;
  exp_t q0[$];
  exp_t q1[$];

  bit          mv[2];
  bit          mpend[2];
  int          mk[2];
  logic [29:0] mtag[2];
  logic [29:0] mpa[2];
  logic [31:0] mdata[2];
  logic [19:0] mlast[2];

  always #5 clk = ~clk;

  assign sd0 = mem[sa0[7:0]];
  assign sd1 = mem[sa1[7:0]];

  inst_fetch_bridge #(.WAIT_CYCLES(2), .ADDR_W(20)) dut0 (
    .clk(clk), .rst(rst_n), .rom_ce_i(ce), .rom_addr_i(addr), .rom_data_o(rd0),
    .stallreq_o(st0), .flush_i(flush), .sram_addr_o(sa0), .sram_ce_n_o(cen0),
    .sram_oe_n_o(oen0), .sram_data_i(sd0));

  inst_fetch_bridge #(.WAIT_CYCLES(1), .ADDR_W(20)) dut1 (
    .clk(clk), .rst(rst_n), .rom_ce_i(ce), .rom_addr_i(addr), .rom_data_o(rd1),
    .stallreq_o(st1), .flush_i(flush), .sram_addr_o(sa1), .sram_ce_n_o(cen1),
    .sram_oe_n_o(oen1), .sram_data_i(sd1));

  // Instruction word at word address a: even half-word is the low half
  function automatic logic [31:0] word_at(input logic [29:0] a);
    int h;
    h = int'(a[6:0]) * 2;
    return {mem[h + 1], mem[h]};
  endfunction

  // Reference: a fetch is a countdown of 2W cycles from the miss; k counts cycles into it
  task automatic model_cycle(input int d, input int w);
    exp_t        e;
    logic [29:0] a;
    bit          hit;
    a = addr[31:2];
    if (!rst_n) begin
      mv[d] = 0; mpend[d] = 0; mk[d] = 0;
      mtag[d] = '0; mpa[d] = '0; mdata[d] = '0; mlast[d] = '0;
    end
    hit     = ce && mv[d] && mtag[d] == a;
    e.data  = hit ? mdata[d] : 32'h0;
    e.stall = ce && !hit;
    e.ce_n  = !mpend[d];
    e.addr  = mpend[d] ? 20'(longint'(mpa[d]) * 2 + (mk[d] > w ? 1 : 0)) : mlast[d];
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    if (!rst_n) return;
    mlast[d] = e.addr;
    if (flush) begin
      mv[d] = 0;
      mpend[d] = 0;
    end else if (!ce) begin
      mpend[d] = 0;
    end else if (mpend[d] ? a != mpa[d] : !hit) begin
      mpa[d] = a;
      mpend[d] = 1;
      mk[d] = 1;
    end else if (mpend[d]) begin
      if (mk[d] == 2 * w) begin
        mv[d] = 1;
        mtag[d] = mpa[d];
        mdata[d] = word_at(mpa[d]);
        mpend[d] = 0;
      end else begin
        mk[d]++;
      end
    end
  endtask

  task automatic drive(input bit r, input bit c, input logic [31:0] a, input bit f);
    @(posedge clk);
    #1;
    rst_n = r;
    ce    = c;
    addr  = a;
    flush = f;
    model_cycle(0, 2);
    model_cycle(1, 1);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h required %h", name, $time, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check("w2_rom_data", rd0, e.data);
        check("w2_stallreq", {31'b0, st0}, {31'b0, e.stall});
        check("w2_sram_ce_n", {31'b0, cen0}, {31'b0, e.ce_n});
        check("w2_sram_oe_n", {31'b0, oen0}, {31'b0, e.ce_n});
        check("w2_sram_addr", {12'b0, sa0}, {12'b0, e.addr});
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("w1_rom_data", rd1, e.data);
        check("w1_stallreq", {31'b0, st1}, {31'b0, e.stall});
        check("w1_sram_ce_n", {31'b0, cen1}, {31'b0, e.ce_n});
        check("w1_sram_oe_n", {31'b0, oen1}, {31'b0, e.ce_n});
        check("w1_sram_addr", {12'b0, sa1}, {12'b0, e.addr});
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [31:0] picks [6];
    int wait_budget;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[8] = 16'h1234;
    mem[9] = 16'hABCD;
    picks = '{32'h10, 32'h14, 32'h20, 32'h24, 32'h30, 32'h0};
    repeat (3) drive(0, 0, 32'h0, 0);
    drive(1, 0, 32'h0, 0);
    repeat (8) drive(1, 1, 32'h10, 0);
    repeat (7) drive(1, 1, 32'h14, 0);
    repeat (4) drive(1, 1, 32'h10, 0);
    repeat (7) drive(1, 1, 32'h20, 0);
    repeat (2) drive(1, 1, 32'h24, 0);
    repeat (2) drive(1, 0, 32'h24, 0);
    repeat (2) drive(1, 1, 32'h20, 0);
    drive(1, 1, 32'h20, 1);
    repeat (6) drive(1, 1, 32'h20, 0);
    repeat (2) drive(1, 1, 32'h30, 0);
    repeat (2) drive(0, 1, 32'h30, 0);
    repeat (6) drive(1, 1, 32'h30, 0);
    a = 32'h10;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(7) == 0) begin
        picks[5] = ($urandom_range(3) == 0) ? ($urandom & 32'hFFFF_FFFF) : ($urandom & 32'h1FF);
        a = picks[$urandom_range(5)];
      end
      drive($urandom_range(199) != 0, $urandom_range(9) != 0, a, $urandom_range(24) == 0);
    end
    wait_budget = 10;
    while ((q0.size() > 0 || q1.size() > 0) && wait_budget > 0) begin
      @(posedge clk);
      wait_budget--;
    end
    n_cmp++;
    if (q0.size() > 0 || q1.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d/%0d entries left, required 0", q0.size(), q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/inst_fetch_bridge.md
# inst_fetch_bridge

Connects the CPU core's instruction port to an external 16-bit asynchronous SRAM/flash. The core's port is a zero-wait 32-bit ROM port (`rom_ce_o`, `rom_addr_o`, `rom_data_i`). Each 32-bit instruction is fetched as two half-word reads with programmable wait states. The last fetched instruction is held in a one-entry buffer, and a stall request is raised while a fetch is outstanding. It sits directly upstream of the core's IF stage; `stallreq_o` is intended as an additional input to the core's pipeline stall controller.

## Interface
- `WAIT_CYCLES`, default 2: clock cycles per half-word access; legal range 1..15.
- `ADDR_W`, default 20: external half-word address width.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rom_ce_i`  in  1  fetch enable, driven from the core's `rom_ce_o`.
- `rom_addr_i`  in  32  instruction byte address, driven from the core's `rom_addr_o`; bits [1:0] ignored.
- `rom_data_o`  out  32  instruction to the core's `rom_data_i`.
- `stallreq_o`  out  1  high while the requested instruction is not yet available.
- `flush_i`  in  1  invalidates the buffer and aborts any fetch in progress.
- `sram_addr_o`  out  ADDR_W  half-word address: `{addr_q[ADDR_W:2], half}`.
- `sram_ce_n_o`  out  1  chip enable, active-low.
- `sram_oe_n_o`  out  1  output enable, active-low.
- `sram_data_i`  in  16  read data from the external device.

## Operation
- Registered state:
  - `state` ∈ {IDLE, RD_LO, RD_HI}
  - `wait_cnt` (4 bits)
  - `addr_q[31:2]` (fetch in progress)
  - `tag_q[31:2]`, `valid_q`, `data_q[31:0]` (buffer)
  - `lo_q[15:0]` (low half captured so far)
- Hit: `rom_ce_i & valid_q & (tag_q == rom_addr_i[31:2])`.
- Outputs, combinational:
  - `rom_data_o` = hit ? `data_q` : 0.
  - `stallreq_o` = `rom_ce_i & ~hit`.
  - `sram_ce_n_o` = `sram_oe_n_o` = ~(state is RD_LO or RD_HI).
  - `sram_addr_o`: half = 0 in RD_LO, 1 in RD_HI. In IDLE it holds the last driven value; 0 after reset.
- Transitions, checked in this priority order:
  1. `flush_i`: `valid_q` ← 0, state → IDLE, `wait_cnt` ← 0.
  2. `~rom_ce_i`: state → IDLE, `wait_cnt` ← 0; partial data discarded; buffer unchanged.
  3. Not IDLE and `rom_addr_i[31:2] != addr_q`: `addr_q` ← new address, state → RD_LO, `wait_cnt` ← 0 (restart).
  4. IDLE, miss: `addr_q` ← `rom_addr_i[31:2]`, state → RD_LO, `wait_cnt` ← 0.
  5. RD_LO: `wait_cnt`++ until it equals WAIT_CYCLES−1. On that cycle, `lo_q` ← `sram_data_i`, `wait_cnt` ← 0, state → RD_HI.
  6. RD_HI: same counting. On the last cycle:
     - `data_q` ← `{sram_data_i, lo_q}`, `tag_q` ← `addr_q`, `valid_q` ← 1
     - state → IDLE
- Little-endian: the even half-word supplies `data_o[15:0]`.
- A hit in IDLE causes no external access.

## Timing
- Reset values:
  - state IDLE; `wait_cnt`, `addr_q`, `tag_q`, `data_q`, `lo_q` = 0; `valid_q` = 0.
  - Resulting outputs: `rom_data_o` = 0, `stallreq_o` = `rom_ce_i`, `sram_ce_n_o` = `sram_oe_n_o` = 1, `sram_addr_o` = 0.
- Asserting reset mid-fetch aborts immediately and asynchronously.
- Miss latency, with the miss first seen in cycle 0:
  - RD_LO occupies cycles 1..W; RD_HI occupies cycles W+1..2W.
  - Data is valid and `stallreq_o` is low in cycle 2W+1.
  - `stallreq_o` is high for exactly 2W+1 cycles.
- `sram_data_i` is sampled at the rising edge that ends the last wait cycle of each half. Each address is held stable for W cycles.
- Hit latency is 0: same-cycle data, `stallreq_o` low.
- The core holds its PC while stalled. An address change mid-fetch costs a full restart (2W+1 further stall cycles from the change).
- `flush_i` and `~rom_ce_i` asserted together: flush semantics apply.
- `flush_i` in the same cycle as an RD_HI completion: the flush wins and the buffer stays invalid.

## Test plan
- **Reset:** drive `rst`=0 with `rom_ce_i`=0 → `rom_data_o`=0, `stallreq_o`=0, `sram_ce_n_o`=`sram_oe_n_o`=1, `sram_addr_o`=0.
- **Miss, W=2:** `rom_addr_i`=0x10; SRAM holds 0x1234 at half-word 8 and 0xABCD at half-word 9 →
  - `stallreq_o` high for 5 cycles
  - `sram_addr_o`=8 for 2 cycles, then 9 for 2 cycles
  - then `rom_data_o`=0xABCD1234, `stallreq_o`=0
- **Hit:** hold 0x10 for 3 more cycles → `stallreq_o`=0, `sram_ce_n_o` stays 1. Then change to 0x14 → a new 5-cycle miss at half-words 10 and 11.
- **Address change:** change `rom_addr_i` to 0x20 during RD_HI of a fetch of 0x10 → restart at half-word 0x10. The buffer ends with the data from 0x20, and the old low half is never exposed.
- **CE drop:** drop `rom_ce_i` during RD_LO → `rom_data_o`=0, `stallreq_o`=0, the next cycle shows IDLE with `sram_ce_n_o`=1. Re-requesting the previously buffered address hits with 0 stall.
- **Flush and WAIT_CYCLES=1:** pulse `flush_i` with a valid buffer at 0x10 → the next request to 0x10 misses with a 3-cycle stall.
